// File: rtl/sync_fifo_byte.sv
// Byte FIFO: unreset storage array, reset pointers with an extra wrap bit,
// registered occupancy level, and push/pop strobes that are ignored when full/empty.
module sync_fifo_byte #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  // Pointer MSB is the wrap bit: equal indices with differing wrap bits means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign level = level_q;

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + LW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + LW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of uart_tx: queues producer bytes and launches one frame
// at a time, pacing on tx_busy so the producer never sees uart timing.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic [LW-1:0] level,
  output logic          overflow
);

  // Handshake: a byte transfers on a clk edge where in_valid & in_ready; in_valid
  // while full is dropped and latches overflow until rst.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       overflow_q, overflow_d;

  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0] fifo_head;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & ~fifo_full;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign overflow  = overflow_q;

  sync_fifo_byte #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The tx_busy guard in IDLE also covers a reset taken mid-frame, since
  // uart_tx itself is not reset and may still be shifting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!fifo_empty && !tx_busy) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop   = (state_q == IDLE) && !fifo_empty && !tx_busy;
    tx_start_d = fifo_pop;
    tx_data_d  = fifo_pop ? fifo_head : tx_data_q;
    overflow_d = overflow_q | (in_valid & fifo_full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with a behavioural uart_tx stand-in (40 clk per frame,
// 12 MHz / 3 MHz baud, 10 bits) and a queue-based reference of the byte stream.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [LW-1:0] level;
  logic          overflow;

  logic frame_busy = 1'b0;
  logic force_busy = 1'b0;
  logic start_seen = 1'b0;
  int   frame_cnt  = 0;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         mdl_cnt = 0;
  logic       exp_ovf = 1'b0;
  logic       acc;
  logic       prev_start = 1'b0;
  int         starts_seen = 0;

  always #5 clk = ~clk;

  assign tx_busy = frame_busy | force_busy;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .level    (level),
    .overflow (overflow)
  );

  // uart_tx stand-in: no reset, busy rises one cycle after the start sample.
  always @(posedge clk) begin
    start_seen <= tx_start && !frame_busy;
    if (start_seen && !frame_busy) begin
      frame_busy <= 1'b1;
      frame_cnt  <= FRAME;
    end else if (frame_cnt > 0) begin
      frame_cnt <= frame_cnt - 1;
      if (frame_cnt == 1) frame_busy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a byte is accepted when fewer than DEPTH bytes wait; a launch
  // (tx_start seen after the edge) removes one waiting byte.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl_cnt = 0;
      exp_ovf = 1'b0;
    end else begin
      acc = in_valid && (mdl_cnt < DEPTH);
      if (in_valid && !acc) exp_ovf = 1'b1;
      if (acc) exp_q.push_back(in_data);
      #1;
      mdl_cnt = mdl_cnt + (acc ? 1 : 0) - (tx_start ? 1 : 0);
    end
  end

  // Monitor: level/ready/overflow every cycle, launched byte against the queue.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      check("level", 32'(level), 32'(mdl_cnt));
      check("in_ready", 32'(in_ready), 32'(mdl_cnt < DEPTH));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      if (tx_start) begin
        starts_seen++;
        check("start_adjacent", 32'(prev_start), 32'd0);
        check("start_into_busy", 32'(tx_busy), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: tx_data=0x%0h with nothing queued at %0t", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e));
        end
      end
    end
    prev_start = tx_start;
  end

  task automatic push_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < limit) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && mdl_cnt == 0 && !tx_busy && !tx_start && !start_seen) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) check("drain_timeout", 32'(n), 32'(limit + 1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int s0;
    int n;

    idle_cycles(3);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Single byte into an empty FIFO: launch visible after the 2nd edge.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_early", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("latency_start", 32'(tx_start), 32'd1);
    check("latency_data", 32'(tx_data), 32'hA5);
    wait_drain(400);
    check("single_level", 32'(level), 32'd0);

    // Burst of 16 while uart is held busy, then a 17th that must drop.
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("burst_full_ready", 32'(in_ready), 32'd0);
    check("burst_full_level", 32'(level), 32'(DEPTH));
    push_byte(8'hFF);
    check("burst_overflow", 32'(overflow), 32'd1);
    force_busy = 1'b0;
    wait_drain(2000);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Continuous stream at roughly the line rate: covers pointer wrap.
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin
      push_byte(8'($urandom_range(0, 255)));
      idle_cycles($urandom_range(20, 55));
    end
    // Dense stream: fills and drops, model decides which bytes survive.
    for (int i = 0; i < 40; i++) begin
      push_byte(8'($urandom_range(0, 255)));
      idle_cycles($urandom_range(0, 3));
    end
    wait_drain(4000);

    // Reset mid-frame of 0x3C with 4 bytes queued.
    push_byte(8'h3C);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
    n = 0;
    while (!frame_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midframe_busy_seen", 32'(frame_busy), 32'd1);
    idle_cycles(10);
    #1 rst = 1'b1;
    idle_cycles(2);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    s0 = starts_seen;
    push_byte(8'h81);
    wait_drain(400);
    check("post_reset_launches", 32'(starts_seen - s0), 32'd1);

    // tx_busy held high for 1000 cycles with data queued: no launch at all.
    force_busy = 1'b1;
    s0 = starts_seen;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
    idle_cycles(1000);
    check("busy_hold_no_start", 32'(starts_seen - s0), 32'd0);
    check("busy_hold_level", 32'(level), 32'd3);
    force_busy = 1'b0;
    wait_drain(1000);
    check("busy_release_launches", 32'(starts_seen - s0), 32'd3);
    check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
